// File: rtl/mem_responder_if.sv
// ============================================================================
// Module : mem_responder_if
// Brief  : Request/response handshake bundle between an initiator and mem_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : Word-organised RAM answering one request at a time after LATENCY wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_responder_if.slave   bus,
  output logic [1:0]       state_out
);

  localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                wr_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;

  logic [31:0]         mem_q [DEPTH];

  logic                err_d;
  logic                access_d;
  logic                mem_we_d;
  logic [C_IDX_W-1:0]  idx_d;

  // Range check is done at full width so addresses beyond DEPTH never alias a valid word.
  assign err_d    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign idx_d    = addr_q[C_IDX_W+1:2];
  assign access_d = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we_d = !reset && access_d && wr_q && !err_d;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_out     = state_q;

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_d][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_wr;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt_q   <= 4'(LATENCY);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_d;
            rsp_rdata_q <= (!wr_q && !err_d) ? mem_q[idx_d] : 32'd0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= 4'd0;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module : tb_mem_responder
// Brief  : Directed self-checking bench for mem_responder at LATENCY 1, 3 and 0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int C_DEPTH = 64;

  logic clk;
  logic reset;
  logic [1:0] st_a, st_b, st_c;

  int n_checks;
  int n_err;

  mem_responder_if ifa ();
  mem_responder_if ifb ();
  mem_responder_if ifc ();

  mem_responder #(.DEPTH(C_DEPTH), .LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .state_out(st_a));
  mem_responder #(.DEPTH(C_DEPTH), .LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .state_out(st_b));
  mem_responder #(.DEPTH(C_DEPTH), .LATENCY(0)) u_dut_c (
    .clk(clk), .reset(reset), .bus(ifc.slave), .state_out(st_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  state;
  } snap_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic rr);
    case (sel)
      0: begin ifa.req_valid = v; ifa.req_wr = wr; ifa.req_addr = a;
               ifa.req_wdata = d; ifa.req_be = be; ifa.rsp_ready = rr; end
      1: begin ifb.req_valid = v; ifb.req_wr = wr; ifb.req_addr = a;
               ifb.req_wdata = d; ifb.req_be = be; ifb.rsp_ready = rr; end
      default: begin ifc.req_valid = v; ifc.req_wr = wr; ifc.req_addr = a;
               ifc.req_wdata = d; ifc.req_be = be; ifc.rsp_ready = rr; end
    endcase
  endtask

  function automatic snap_t snap(input int sel);
    snap_t s;
    case (sel)
      0:       s = '{ifa.rsp_valid, ifa.req_ready, ifa.rsp_rdata, ifa.rsp_err, st_a};
      1:       s = '{ifb.rsp_valid, ifb.req_ready, ifb.rsp_rdata, ifb.rsp_err, st_b};
      default: s = '{ifc.rsp_valid, ifc.req_ready, ifc.rsp_rdata, ifc.rsp_err, st_c};
    endcase
    return s;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 3 : 0;
  endfunction

  // One complete transaction; hold > 0 stalls the response for that many cycles.
  task automatic do_req(input int sel, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err);
    snap_t s;
    int    n;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, d, be, (hold == 0));
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, (hold == 0));
    n = 0;
    s = snap(sel);
    while (!s.valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      s = snap(sel);
    end
    chk("latency", 32'(n), 32'(lat_of(sel) + 1));
    rdata = s.rdata;
    err   = s.err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      s = snap(sel);
      chk("bp_valid", 32'(s.valid), 32'd1);
      chk("bp_rdata", s.rdata, rdata);
      chk("bp_err",   32'(s.err), 32'(err));
      chk("bp_ready", 32'(s.ready), 32'd0);
      chk("bp_state", 32'(s.state), 32'd2);
    end
    if (hold > 0) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    @(posedge clk); #1;
    s = snap(sel);
    chk("ret_state", 32'(s.state), 32'd0);
    chk("ret_valid", 32'(s.valid), 32'd0);
    chk("ret_rdata", s.rdata, 32'd0);
    chk("ret_ready", 32'(s.ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    snap_t       s;
    n_checks = 0;
    n_err    = 0;

    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    drive(2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      s = snap(0);
      chk("rst_ready", 32'(s.ready), 32'd1);
      chk("rst_valid", 32'(s.valid), 32'd0);
      chk("rst_rdata", s.rdata, 32'd0);
      chk("rst_err",   32'(s.err), 32'd0);
      chk("rst_state", 32'(s.state), 32'd0);
      chk("rst_state_b", 32'(st_b), 32'd0);
      chk("rst_state_c", 32'(st_c), 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);

    // LATENCY 1: full write, read back, partial byte-enable merge
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    chk("wr10_rdata", rd, 32'd0);
    chk("wr10_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
    chk("rd10_rdata", rd, 32'hDEAD_BEEF);
    chk("rd10_err", 32'(er), 32'd0);
    do_req(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd, er);
    chk("wrbe_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
    chk("rdbe_rdata", rd, 32'hDE22_BE44);

    // Misaligned and out-of-range
    do_req(0, 1'b0, 32'h13, 32'd0, 4'h0, 0, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    do_req(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 0, rd, er);
    do_req(0, 1'b1, 32'(4 * C_DEPTH), 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, rd, er);
    chk("rd0_after_oor", rd, 32'hCAFE_F00D);
    chk("rd0_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'(4 * C_DEPTH - 4), 32'd0, 4'h0, 0, rd, er);
    chk("last_word_err", 32'(er), 32'd0);

    // Backpressure on a read, then zero byte-enable write is a no-op
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 5, rd, er);
    chk("bp_read_rdata", rd, 32'hDE22_BE44);
    do_req(0, 1'b1, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("be0_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
    chk("be0_rdata", rd, 32'hDE22_BE44);

    // LATENCY 3: establish contents, then abort a write with reset in WAIT
    do_req(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, rd, er);
    do_req(1, 1'b0, 32'h20, 32'd0, 4'h0, 0, rd, er);
    chk("b_rd20", rd, 32'h1234_5678);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 4'hF, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1);
    chk("b_in_wait", 32'(st_b), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s = snap(1);
    chk("b_abort_state", 32'(s.state), 32'd0);
    chk("b_abort_ready", 32'(s.ready), 32'd1);
    chk("b_abort_valid", 32'(s.valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("b_no_resp", 32'(ifb.rsp_valid), 32'd0);
    do_req(1, 1'b0, 32'h20, 32'd0, 4'h0, 0, rd, er);
    chk("b_rd20_after_abort", rd, 32'h1234_5678);

    // LATENCY 0
    do_req(2, 1'b1, 32'h8, 32'hA5A5_0F0F, 4'hF, 0, rd, er);
    chk("c_wr_err", 32'(er), 32'd0);
    do_req(2, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er);
    chk("c_rd_rdata", rd, 32'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
